// File: rtl/iq_pair_packer.sv
// Pairs I/Q ADC samples with skew checking and writes framed {I,Q} words
// (with a periodic header) to a 64-bit FIFO write port.
module iq_pair_packer #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned FRAME_LEN  = 512,
    parameter int unsigned SKEW_MAX   = 8,
    parameter logic [31:0] HDR_MAGIC  = 32'hA5A55A5A
) (
    input  logic                    clk,
    input  logic                    arstn,
    input  logic                    enable,
    input  logic [DATA_WIDTH-1:0]   i_data,
    input  logic                    i_valid,
    input  logic [DATA_WIDTH-1:0]   q_data,
    input  logic                    q_valid,
    input  logic                    fifo_full,
    output logic [2*DATA_WIDTH-1:0] fifo_data,
    output logic                    fifo_we,
    output logic [15:0]             frame_cnt,
    output logic [15:0]             overrun_cnt,
    output logic                    skew_err
);

    localparam int unsigned SW = $clog2(SKEW_MAX + 1);
    localparam logic [15:0] FRAME_LEN16 = 16'(FRAME_LEN);
    localparam logic [SW-1:0] SKEW_LIM = SW'(SKEW_MAX);

    typedef enum logic [1:0] {IDLE, HDR, PAIR} state_t;

    state_t                  state_q, state_d;
    logic                    enable_q, enable_d;
    logic                    i_got_q, i_got_d, q_got_q, q_got_d;
    logic [DATA_WIDTH-1:0]   i_hold_q, i_hold_d, q_hold_q, q_hold_d;
    logic [SW-1:0]           skew_cnt_q, skew_cnt_d;
    logic                    pend_valid_q, pend_valid_d;
    logic [2*DATA_WIDTH-1:0] pend_data_q, pend_data_d;
    logic                    hdr_due_q, hdr_due_d;
    logic [15:0]             pair_idx_q, pair_idx_d;
    logic [15:0]             frame_cnt_q, frame_cnt_d;
    logic [15:0]             overrun_q, overrun_d;
    logic                    skew_err_q, skew_err_d;
    logic [2*DATA_WIDTH-1:0] fifo_data_q, fifo_data_d;
    logic                    fifo_we_q, fifo_we_d;

    logic        i_got_eff, q_got_eff;
    logic        release_pend, drop_cmp, drop_fsm, skew_set;
    logic [16:0] ov_sum;

    always_comb begin
        state_d      = state_q;
        enable_d     = enable;
        i_got_d      = i_got_q;
        q_got_d      = q_got_q;
        i_hold_d     = i_hold_q;
        q_hold_d     = q_hold_q;
        skew_cnt_d   = skew_cnt_q;
        pend_valid_d = pend_valid_q;
        pend_data_d  = pend_data_q;
        hdr_due_d    = hdr_due_q;
        pair_idx_d   = pair_idx_q;
        frame_cnt_d  = frame_cnt_q;
        fifo_data_d  = fifo_data_q;
        fifo_we_d    = 1'b0;
        release_pend = 1'b0;
        drop_cmp     = 1'b0;
        drop_fsm     = 1'b0;
        skew_set     = 1'b0;
        i_got_eff    = i_got_q | i_valid;
        q_got_eff    = q_got_q | q_valid;

        if (!enable) begin
            i_got_d      = 1'b0;
            q_got_d      = 1'b0;
            skew_cnt_d   = '0;
            pend_valid_d = 1'b0;
            state_d      = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (pend_valid_q) state_d = hdr_due_q ? HDR : PAIR;
                end
                HDR: begin
                    if (!fifo_full) begin
                        fifo_we_d   = 1'b1;
                        fifo_data_d = (2*DATA_WIDTH)'({HDR_MAGIC, frame_cnt_q, FRAME_LEN16});
                        frame_cnt_d = frame_cnt_q + 16'd1;
                        hdr_due_d   = 1'b0;
                        state_d     = PAIR;
                    end else begin
                        pend_valid_d = 1'b0;
                        release_pend = 1'b1;
                        drop_fsm     = 1'b1;
                        state_d      = IDLE;
                    end
                end
                PAIR: begin
                    if (!fifo_full) begin
                        fifo_we_d   = 1'b1;
                        fifo_data_d = pend_data_q;
                        if (pair_idx_q + 16'd1 == FRAME_LEN16) begin
                            pair_idx_d = '0;
                            hdr_due_d  = 1'b1;
                        end else begin
                            pair_idx_d = pair_idx_q + 16'd1;
                        end
                    end else begin
                        drop_fsm = 1'b1;
                    end
                    pend_valid_d = 1'b0;
                    release_pend = 1'b1;
                    state_d      = IDLE;
                end
                default: state_d = IDLE;
            endcase

            if (i_valid) i_hold_d = i_data;
            if (q_valid) q_hold_d = q_data;
            if ((i_valid && i_got_q) || (q_valid && q_got_q)) skew_set = 1'b1;

            // A pending slot being released this cycle may accept the new pair.
            if (i_got_eff && q_got_eff) begin
                i_got_d    = 1'b0;
                q_got_d    = 1'b0;
                skew_cnt_d = '0;
                if (!pend_valid_q || release_pend) begin
                    pend_valid_d = 1'b1;
                    pend_data_d  = {(i_valid ? i_data : i_hold_q), (q_valid ? q_data : q_hold_q)};
                end else begin
                    drop_cmp = 1'b1;
                end
            end else if (i_got_eff || q_got_eff) begin
                i_got_d = i_got_eff;
                q_got_d = q_got_eff;
                if (i_valid || q_valid) begin
                    skew_cnt_d = '0;
                end else if (skew_cnt_q + SW'(1) == SKEW_LIM) begin
                    i_got_d    = 1'b0;
                    q_got_d    = 1'b0;
                    skew_cnt_d = '0;
                    skew_set   = 1'b1;
                end else begin
                    skew_cnt_d = skew_cnt_q + SW'(1);
                end
            end else begin
                skew_cnt_d = '0;
            end
        end

        ov_sum     = {1'b0, overrun_q} + 17'(drop_cmp) + 17'(drop_fsm);
        overrun_d  = ov_sum[16] ? '1 : ov_sum[15:0];
        skew_err_d = skew_err_q | skew_set;

        if (enable && !enable_q) begin
            frame_cnt_d = '0;
            overrun_d   = '0;
            skew_err_d  = 1'b0;
            pair_idx_d  = '0;
            hdr_due_d   = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            state_q      <= IDLE;
            enable_q     <= 1'b0;
            i_got_q      <= 1'b0;
            q_got_q      <= 1'b0;
            i_hold_q     <= '0;
            q_hold_q     <= '0;
            skew_cnt_q   <= '0;
            pend_valid_q <= 1'b0;
            pend_data_q  <= '0;
            hdr_due_q    <= 1'b1;
            pair_idx_q   <= '0;
            frame_cnt_q  <= '0;
            overrun_q    <= '0;
            skew_err_q   <= 1'b0;
            fifo_data_q  <= '0;
            fifo_we_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            enable_q     <= enable_d;
            i_got_q      <= i_got_d;
            q_got_q      <= q_got_d;
            i_hold_q     <= i_hold_d;
            q_hold_q     <= q_hold_d;
            skew_cnt_q   <= skew_cnt_d;
            pend_valid_q <= pend_valid_d;
            pend_data_q  <= pend_data_d;
            hdr_due_q    <= hdr_due_d;
            pair_idx_q   <= pair_idx_d;
            frame_cnt_q  <= frame_cnt_d;
            overrun_q    <= overrun_d;
            skew_err_q   <= skew_err_d;
            fifo_data_q  <= fifo_data_d;
            fifo_we_q    <= fifo_we_d;
        end
    end

    assign fifo_data   = fifo_data_q;
    assign fifo_we     = fifo_we_q;
    assign frame_cnt   = frame_cnt_q;
    assign overrun_cnt = overrun_q;
    assign skew_err    = skew_err_q;

endmodule

// File: tb/tb_iq_pair_packer.sv
// Scoreboard bench for iq_pair_packer: expected FIFO words are queued as
// stimulus is driven and checked when fifo_we fires.
module tb_iq_pair_packer;

    logic        clk = 1'b0;
    logic        arstn;
    logic        enable;
    logic [31:0] i_data, q_data;
    logic        i_valid, q_valid;
    logic        fifo_full;
    logic [63:0] fifo_data;
    logic        fifo_we;
    logic [15:0] frame_cnt, overrun_cnt;
    logic        skew_err;

    int          errors = 0;
    int          checks = 0;
    int          nwrites = 0;
    int          we_run = 0;
    logic [63:0] exp_q[$];
    logic [15:0] m_frame;
    int          m_idx;
    logic        m_hdr_due;

    iq_pair_packer #(
        .DATA_WIDTH(32),
        .FRAME_LEN (512),
        .SKEW_MAX  (8),
        .HDR_MAGIC (32'hA5A55A5A)
    ) dut (
        .clk        (clk),
        .arstn      (arstn),
        .enable     (enable),
        .i_data     (i_data),
        .i_valid    (i_valid),
        .q_data     (q_data),
        .q_valid    (q_valid),
        .fifo_full  (fifo_full),
        .fifo_data  (fifo_data),
        .fifo_we    (fifo_we),
        .frame_cnt  (frame_cnt),
        .overrun_cnt(overrun_cnt),
        .skew_err   (skew_err)
    );

    always #5 clk = ~clk;

    // Write monitor: pops the scoreboard on every FIFO write.
    always @(negedge clk) begin
        if (arstn) begin
            if (fifo_we) begin
                logic [63:0] e;
                we_run++;
                nwrites++;
                checks++;
                if (we_run > 2) begin
                    errors++;
                    $display("FAIL we_burst: fifo_we high %0d consecutive cycles, required <= 2", we_run);
                end
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_write: got %h, required no write", fifo_data);
                end else begin
                    e = exp_q.pop_front();
                    if (fifo_data !== e) begin
                        errors++;
                        $display("FAIL fifo_word: got %h, required %h", fifo_data, e);
                    end
                end
            end else begin
                we_run = 0;
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
        $fatal(1);
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic push_pair(input logic [31:0] iv, input logic [31:0] qv);
        if (m_hdr_due) begin
            exp_q.push_back({32'hA5A55A5A, m_frame, 16'd512});
            m_frame   = m_frame + 16'd1;
            m_hdr_due = 1'b0;
        end
        exp_q.push_back({iv, qv});
        m_idx++;
        if (m_idx == 512) begin
            m_idx     = 0;
            m_hdr_due = 1'b1;
        end
    endtask

    task automatic drive_pair(input logic [31:0] iv, input logic [31:0] qv, input int lag);
        i_data  = iv;
        i_valid = 1'b1;
        if (lag == 0) begin
            q_data  = qv;
            q_valid = 1'b1;
        end
        tick();
        i_valid = 1'b0;
        q_valid = 1'b0;
        if (lag > 0) begin
            repeat (lag - 1) tick();
            q_data  = qv;
            q_valid = 1'b1;
            tick();
            q_valid = 1'b0;
        end
        repeat (3) tick();
    endtask

    task automatic send_pair(input logic [31:0] iv, input logic [31:0] qv, input int lag);
        push_pair(iv, qv);
        drive_pair(iv, qv, lag);
    endtask

    task automatic drain(input string name);
        for (int k = 0; k < 50 && exp_q.size() != 0; k++) tick();
        repeat (4) tick();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s_drain: %0d words outstanding, required 0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic reenable;
        enable = 1'b0;
        repeat (3) tick();
        enable = 1'b1;
        tick();
        m_frame   = 16'd0;
        m_idx     = 0;
        m_hdr_due = 1'b1;
    endtask

    task automatic check_counters(input string name, input logic [15:0] fc,
                                  input logic [15:0] oc, input logic se);
        checks++;
        if (frame_cnt !== fc) begin
            errors++;
            $display("FAIL %s_frame_cnt: got %0d, required %0d", name, frame_cnt, fc);
        end
        checks++;
        if (overrun_cnt !== oc) begin
            errors++;
            $display("FAIL %s_overrun_cnt: got %0d, required %0d", name, overrun_cnt, oc);
        end
        checks++;
        if (skew_err !== se) begin
            errors++;
            $display("FAIL %s_skew_err: got %b, required %b", name, skew_err, se);
        end
    endtask

    task automatic test_reset;
        checks++;
        if (fifo_we !== 1'b0 || fifo_data !== 64'h0) begin
            errors++;
            $display("FAIL reset_fifo: we=%b data=%h, required 0/0", fifo_we, fifo_data);
        end
        check_counters("reset", 16'd0, 16'd0, 1'b0);
    endtask

    task automatic test_single_pair;
        int w0;
        w0 = nwrites;
        send_pair(32'h11111111, 32'h22222222, 0);
        drain("single");
        checks++;
        if (nwrites - w0 != 2) begin
            errors++;
            $display("FAIL single_writes: got %0d writes, required 2", nwrites - w0);
        end
        check_counters("single", 16'd1, 16'd0, 1'b0);
    endtask

    task automatic test_frame_wrap;
        reenable();
        for (int k = 0; k < 513; k++) begin
            logic [31:0] iv;
            iv = 32'h10000000 + 32'(k);
            send_pair(iv, ~iv, 3);
        end
        drain("frame");
        check_counters("frame", 16'd2, 16'd0, 1'b0);
    endtask

    task automatic test_skew_orphan;
        i_data  = 32'hDEADBEEF;
        i_valid = 1'b1;
        tick();
        i_valid = 1'b0;
        repeat (11) tick();
        checks++;
        if (skew_err !== 1'b1) begin
            errors++;
            $display("FAIL skew_flag: got %b, required 1", skew_err);
        end
        send_pair(32'h33333333, 32'h44444444, 2);
        drain("skew");
    endtask

    task automatic test_overrun;
        reenable();
        fifo_full = 1'b1;
        for (int k = 0; k < 3; k++) drive_pair(32'h50000000 + 32'(k), 32'h60000000 + 32'(k), 1);
        repeat (3) tick();
        fifo_full = 1'b0;
        checks++;
        if (overrun_cnt !== 16'd3) begin
            errors++;
            $display("FAIL overrun_count: got %0d, required 3", overrun_cnt);
        end
        send_pair(32'h77777777, 32'h88888888, 1);
        drain("overrun");
        check_counters("overrun", 16'd1, 16'd3, 1'b0);
    endtask

    task automatic test_enable_drop;
        int w0;
        w0 = nwrites;
        i_data  = 32'h99999999;
        i_valid = 1'b1;
        tick();
        i_valid = 1'b0;
        tick();
        enable = 1'b0;
        repeat (3) tick();
        q_data  = 32'hAAAAAAAA;
        q_valid = 1'b1;
        tick();
        q_valid = 1'b0;
        repeat (3) tick();
        checks++;
        if (nwrites != w0) begin
            errors++;
            $display("FAIL enable_nowrite: got %0d writes, required 0", nwrites - w0);
        end
        enable = 1'b1;
        tick();
        m_frame   = 16'd0;
        m_idx     = 0;
        m_hdr_due = 1'b1;
        check_counters("reenable", 16'd0, 16'd0, 1'b0);
        send_pair(32'hBBBBBBBB, 32'hCCCCCCCC, 0);
        drain("reenable");
    endtask

    task automatic test_async_reset;
        bit seen;
        reenable();
        seen    = 1'b0;
        i_data  = 32'hCAFEF00D;
        q_data  = 32'h0BADBEEF;
        i_valid = 1'b1;
        q_valid = 1'b1;
        tick();
        i_valid = 1'b0;
        q_valid = 1'b0;
        for (int k = 0; k < 10 && !seen; k++) begin
            tick();
            if (fifo_we === 1'b1) seen = 1'b1;
        end
        checks++;
        if (!seen || fifo_data !== 64'hA5A55A5A_0000_0200) begin
            errors++;
            $display("FAIL arst_header: seen=%b data=%h, required 1/%h", seen, fifo_data, 64'hA5A55A5A_0000_0200);
        end
        arstn = 1'b0;
        #1;
        checks++;
        if (fifo_we !== 1'b0 || fifo_data !== 64'h0) begin
            errors++;
            $display("FAIL arst_fifo: we=%b data=%h, required 0/0", fifo_we, fifo_data);
        end
        check_counters("arst", 16'd0, 16'd0, 1'b0);
        exp_q.delete();
        tick();
        arstn = 1'b1;
        tick();
        m_frame   = 16'd0;
        m_idx     = 0;
        m_hdr_due = 1'b1;
        send_pair(32'h12345678, 32'h9ABCDEF0, 4);
        drain("arst");
        check_counters("arst_after", 16'd1, 16'd0, 1'b0);
    endtask

    initial begin
        arstn     = 1'b0;
        enable    = 1'b0;
        i_data    = '0;
        q_data    = '0;
        i_valid   = 1'b0;
        q_valid   = 1'b0;
        fifo_full = 1'b0;
        m_frame   = 16'd0;
        m_idx     = 0;
        m_hdr_due = 1'b1;
        repeat (2) tick();
        arstn = 1'b1;
        tick();
        test_reset();
        enable = 1'b1;
        tick();
        test_single_pair();
        test_frame_wrap();
        test_skew_orphan();
        test_overrun();
        test_enable_drop();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
